multi_cycle_ctrl: RTL
=====================

// Module: multi_cycle_ctrl
// PURPOSE
//  Main control FSM of the multi-cycle MIPS datapath; sits directly upstream of the ALU control unit.
//  Decodes the IR opcode over FETCH/DECODE/EXEC/MEM/WB steps and drives every datapath enable/mux select.
//  Provides ALUOp (00 add, 01 sub, 10 R-type funct) and waits on a memory-ready handshake.
// PARAMETERS
//  STATE_W   4          state register width
//  OP_RTYPE  6'b000000  R-type opcode
//  OP_LW     6'b100011  load word
//  OP_SW     6'b101011  store word
//  OP_BEQ    6'b000100  branch-if-equal
//  OP_J      6'b000010  jump
//  OP_ADDI   6'b001000  add immediate (used only with ADDI_EN)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  op         in   6  IR[31:26], valid from DECODE onward
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory handshake: access completes in the cycle it is high
//  pc_en      out  1  PC load = PCWrite | (PCWriteCond & zero)
//  iord       out  1  0: address=PC, 1: address=ALUOut
//  mem_read   out  1  memory read request
//  mem_write  out  1  memory write request
//  ir_write   out  1  IR load
//  mem_to_reg out  1  0: write ALUOut, 1: write MDR
//  reg_dst    out  1  0: rt, 1: rd
//  reg_write  out  1  register file write
//  alu_src_a  out  1  0: PC, 1: A
//  alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  alu_op     out  2  to ALU control: 00 add, 01 sub, 10 funct
//  pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
//  instr_done out  1  one-cycle pulse in the last state of each instruction
//  illegal_op out  1  one-cycle pulse in DECODE on an unsupported opcode
//  state      out  STATE_W  current state, debug
// BEHAVIOUR
//  - Moore FSM; outputs decode from the registered state only (plus zero/mem_ready gating as noted).
//  - States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 RWB=7 BEQ=8 JUMP=9 [ADDIEX=10 ADDIWB=11].
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00;
//    ir_write and pc_en only when mem_ready=1; stay in FETCH while mem_ready=0 (PC increments exactly once).
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by op:
//    LW/SW->MEMADR, RTYPE->EXEC, BEQ->BEQ, J->JUMP; any other op->FETCH with illegal_op=1.
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD for LW, MEMWR for SW.
//  - MEMRD: mem_read=1, iord=1; hold until mem_ready, then MEMWB.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
//  - MEMWR: mem_write=1, iord=1; hold until mem_ready; instr_done=1 in the mem_ready cycle -> FETCH.
//  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> RWB.
//  - RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
//  - BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_en=zero, instr_done=1 -> FETCH.
//  - JUMP: pc_source=10, pc_en=1, instr_done=1 -> FETCH.
//  - Latency: R-type 4, LW 5, SW 4, BEQ 3, J 3 cycles, plus one cycle per mem_ready=0 wait cycle.
//  - Every output not listed for a state is 0.
//  - While rst_n=0: state=FETCH and all outputs forced to 0. After release, FETCH starts on the next edge.
//  - Reset asserted mid-instruction aborts immediately: no partial write may follow, even if mem_ready is high.
//  - op is sampled only in DECODE; changes to op in other states are ignored.
//  - Unused state encodings (10-15 without ADDI_EN, 12-15 with it) -> FETCH next cycle, all outputs 0.
// CONFIGURATION
//  - ADDI_EN defined: OP_ADDI in DECODE -> ADDIEX (alu_src_a=1, alu_src_b=10, alu_op=00)
//    -> ADDIWB (reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1) -> FETCH; 4-cycle latency.
//  - ADDI_EN undefined: OP_ADDI is illegal (illegal_op pulse, return to FETCH); states 10/11 are unused.
// STRUCTURE
//  - Shared header ctrl_defs.vh: state encodings, opcode constants, ALUOp/ALUSrcB/PCSource codes
//    (also included by the ALU control unit for the ALUOp codes).
//  - One sub-module, ctrl_out_decode: purely combinational state -> control-word decoder.
//    Next-state logic and the state register stay in the top module.
// TESTING
//  - Reset mid-MEMWR with mem_ready=1 -> mem_write=0 immediately, state=0, all outputs 0.
//  - R-type (op=0) with mem_ready=1 -> states 0,1,6,7; alu_op=10 in EXEC; reg_write=1 and reg_dst=1 in RWB.
//  - LW with mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, instr_done in MEMWB, 7 cycles total.
//  - BEQ with zero=1 -> pc_en=1, pc_source=01 in BEQ; with zero=0 -> pc_en=0.
//  - J, then op=6'b111111 -> JUMP pc_source=10; illegal_op pulse in DECODE and return to FETCH.
//  - ADDI (op=001000): with ADDI_EN -> states 0,1,10,11, reg_write=1, reg_dst=0; without it -> illegal_op.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// ============================================================================
// | Module   : multi_cycle_ctrl_pkg                                          |
// | Purpose  : Shared definitions for the multi-cycle MIPS main controller:  |
// |            state encodings, opcode constants, ALUOp / ALUSrcB / PCSource |
// |            codes, the control-word struct and an opcode legality check.  |
// |            The ALUOp codes are also what the ALU control unit decodes.   |
// | Macro    : ADDI_EN - when defined, ADDI gets its own ADDIEX/ADDIWB path; |
// |            when undefined, ADDI is reported as an illegal opcode.        |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

package multi_cycle_ctrl_pkg;

   localparam int STATE_W = 4;

   // Opcodes, IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

`ifdef ADDI_EN
   localparam bit ADDI_ENABLED = 1'b1;
`else
   localparam bit ADDI_ENABLED = 1'b0;
`endif

   // ALUOp codes handed to the ALU control unit
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALU B-operand select
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   // Next-PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BEQ    = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_e;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic op_supported(input logic [5:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
         OP_ADDI:                              ok = ADDI_ENABLED;
         default:                              ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi_cycle_ctrl_out_decode.sv
// ============================================================================
// | Module   : multi_cycle_ctrl_out_decode                                   |
// | Purpose  : Purely combinational state -> control-word decoder for the    |
// |            multi-cycle MIPS controller (Moore outputs, with the zero and |
// |            mem_ready gating folded in).                                  |
// | Ports    : state     in  STATE_W  registered FSM state                   |
// |            op        in  6        IR opcode (only looked at in DECODE)   |
// |            zero      in  1        ALU zero flag (BEQ pc_en)              |
// |            mem_ready in  1        memory handshake                       |
// |            ctrl      out ctrl_t   full datapath control word             |
// | Macro    : ADDI_EN (through the package ADDI_ENABLED constant)           |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

module multi_cycle_ctrl_out_decode
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   input  logic [5:0]         op,
   input  logic               zero,
   input  logic               mem_ready,
   output ctrl_t              ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            // IR and PC load only in the completing cycle, so PC moves once
            ctrl.ir_write  = mem_ready;
            ctrl.pc_en     = mem_ready;
         end
         S_DECODE: begin
            // Branch target precomputed while the opcode is decoded
            ctrl.alu_src_b  = SRCB_IMMSH2;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.illegal_op = ~op_supported(op);
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write  = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BEQ: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRCB_B;
            ctrl.alu_op     = ALUOP_SUB;
            ctrl.pc_source  = PCSRC_ALUOUT;
            // PCWriteCond & zero
            ctrl.pc_en      = zero;
            ctrl.instr_done = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_source  = PCSRC_JUMP;
            ctrl.pc_en      = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_ADDIEX: begin
            if (ADDI_ENABLED) begin
               ctrl.alu_src_a = 1'b1;
               ctrl.alu_src_b = SRCB_IMM;
            end
         end
         S_ADDIWB: begin
            if (ADDI_ENABLED) begin
               ctrl.reg_write  = 1'b1;
               ctrl.instr_done = 1'b1;
            end
         end
         default: ctrl = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_ctrl.sv
// ============================================================================
// | Module   : multi_cycle_ctrl                                              |
// | Purpose  : Main control FSM of the multi-cycle MIPS datapath. Steps      |
// |            FETCH/DECODE/EXEC/MEM/WB, drives every datapath enable and    |
// |            mux select, waits on the memory-ready handshake.              |
// | Ports    : clk, rst_n (async active-low), op[5:0], zero, mem_ready       |
// |            -> pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg,    |
// |               reg_dst, reg_write, alu_src_a, alu_src_b[1:0],             |
// |               alu_op[1:0], pc_source[1:0], instr_done, illegal_op,       |
// |               state[STATE_W-1:0] (debug)                                 |
// | Macro    : ADDI_EN - enables the ADDIEX/ADDIWB path                      |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
`default_nettype none

module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         op,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_en,
   output logic               iord,
   output logic               mem_read,
   output logic               mem_write,
   output logic               ir_write,
   output logic               mem_to_reg,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic [1:0]         pc_source,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   state_e state_q, state_d;
   // Low from reset until the first edge after release: keeps outputs
   // quiet and holds FETCH so the first fetch starts on that edge.
   logic   active_q, active_d;
   // LW vs SW captured in DECODE; op is not trusted after that state
   logic   is_lw_q, is_lw_d;

   ctrl_t  dec_ctrl;
   ctrl_t  out_ctrl;

   always_comb begin
      state_d  = state_q;
      is_lw_d  = is_lw_q;
      active_d = 1'b1;
      if (!active_q) begin
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
               is_lw_d = (op == OP_LW);
               case (op)
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_RTYPE:     state_d = S_EXEC;
                  OP_BEQ:       state_d = S_BEQ;
                  OP_J:         state_d = S_JUMP;
                  OP_ADDI: begin
                     if (ADDI_ENABLED) state_d = S_ADDIEX;
                     else              state_d = S_FETCH;
                  end
                  default:      state_d = S_FETCH;
               endcase
            end
            S_MEMADR: begin
               if (is_lw_q) state_d = S_MEMRD;
               else         state_d = S_MEMWR;
            end
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: begin
               if (ADDI_ENABLED) state_d = S_ADDIWB;
               else              state_d = S_FETCH;
            end
            S_ADDIWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         active_q <= 1'b0;
         is_lw_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         is_lw_q  <= is_lw_d;
      end
   end

   multi_cycle_ctrl_out_decode u_out_decode (
      .state     (state_q),
      .op        (op),
      .zero      (zero),
      .mem_ready (mem_ready),
      .ctrl      (dec_ctrl)
   );

   // Reset clears active_q asynchronously, so a mid-instruction reset
   // kills any write strobe immediately regardless of mem_ready.
   assign out_ctrl   = active_q ? dec_ctrl : '0;

   assign pc_en      = out_ctrl.pc_en;
   assign iord       = out_ctrl.iord;
   assign mem_read   = out_ctrl.mem_read;
   assign mem_write  = out_ctrl.mem_write;
   assign ir_write   = out_ctrl.ir_write;
   assign mem_to_reg = out_ctrl.mem_to_reg;
   assign reg_dst    = out_ctrl.reg_dst;
   assign reg_write  = out_ctrl.reg_write;
   assign alu_src_a  = out_ctrl.alu_src_a;
   assign alu_src_b  = out_ctrl.alu_src_b;
   assign alu_op     = out_ctrl.alu_op;
   assign pc_source  = out_ctrl.pc_source;
   assign instr_done = out_ctrl.instr_done;
   assign illegal_op = out_ctrl.illegal_op;
   assign state      = state_q;

endmodule

`default_nettype wire
